// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the single MMU memory bus between NUM_REQ
// requesters (Ibex instruction fetch, Ibex data, Vicuna vector LSU).
//
// One transaction is outstanding at a time. In IDLE the winner is picked
// combinationally and granted. Its request fields are latched and held on the
// mem_* side for the whole BUSY phase. The MMU response (or a watchdog timeout)
// is returned one cycle later as a registered one-hot pulse to the owner.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   req_i .. wdata_i   packed per-requester request fields (requester k at slot k)
//   gnt_o           one-hot grant pulse (combinational, IDLE only)
//   rvalid_o/err_o  one-hot registered response / error pulse to the owner
//   rdata_o         read data, non-zero only alongside rvalid_o
//   mem_*_o         latched request towards the MMU
//   mem_*_i         MMU response
//   busy_o          transaction outstanding
//   timeout_o       watchdog abort pulse
module mem_bus_arbiter #(
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*32-1:0]      addr_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*MEM_W/8-1:0] be_i,
  input  logic [NUM_REQ*MEM_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [MEM_W-1:0]           rdata_o,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  output logic                       mem_we_o,
  output logic [MEM_W/8-1:0]         mem_be_o,
  output logic [MEM_W-1:0]           mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic                       mem_err_i,
  input  logic [MEM_W-1:0]           mem_rdata_i,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int unsigned BeW  = MEM_W / 8;
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [BeW-1:0]     be_q, be_d;
  logic [MEM_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [MEM_W-1:0]   rdata_q, rdata_d;
  logic               timeout_q, timeout_d;

  logic               any_req;
  logic [PtrW-1:0]    winner;
  int unsigned        idx;
  int unsigned        sel;
  logic [PtrW:0]      ptr_inc;
  logic [PtrW-1:0]    next_ptr;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PtrW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        winner  = PtrW'(idx);
      end
    end
  end

  // Pointer moves just past the owner once its access terminates.
  always_comb begin
    ptr_inc  = {1'b0, owner_q} + 1'b1;
    next_ptr = (ptr_inc >= (PtrW + 1)'(NUM_REQ)) ? '0 : ptr_inc[PtrW-1:0];
  end

  assign sel = int'(winner);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rvalid_d  = '0;
    err_d     = '0;
    rdata_d   = '0;
    timeout_d = 1'b0;
    gnt_o     = '0;

    unique case (state_q)
      StIdle: begin
        // Responses seen here are spurious and deliberately ignored.
        if (any_req) begin
          gnt_o   = to_onehot(winner);
          owner_d = winner;
          addr_d  = addr_i[32*sel +: 32];
          we_d    = we_i[sel];
          be_d    = be_i[BeW*sel +: BeW];
          wdata_d = wdata_i[MEM_W*sel +: MEM_W];
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Error beats rvalid; any real response beats the watchdog.
        if (mem_err_i) begin
          err_d    = to_onehot(owner_q);
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end else if (mem_rvalid_i) begin
          rvalid_d = to_onehot(owner_q);
          rdata_d  = mem_rdata_i;
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end else if (cnt_q == TermCnt) begin
          err_d     = to_onehot(owner_q);
          timeout_d = 1'b1;
          state_d   = StIdle;
          rr_ptr_d  = next_ptr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // No grant may be seen while reset is being applied.
    if (!rst) begin
      gnt_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rvalid_q  <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o      = (state_q == StBusy);
  assign mem_req_o   = (state_q == StBusy);
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a response scoreboard: each MMU
// response driven pushes the expected owner pulse, popped one cycle later.
module tb_mem_bus_arbiter;

  localparam int unsigned MEM_W = 32;
  localparam int unsigned NR    = 3;
  localparam int unsigned TO    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_i;
  logic [NR*32-1:0]  addr_i;
  logic [NR-1:0]     we_i;
  logic [NR*4-1:0]   be_i;
  logic [NR*32-1:0]  wdata_i;
  logic [NR-1:0]     gnt_o, rvalid_o, err_o;
  logic [31:0]       rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [31:0]       mem_addr_o, mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              mem_rvalid_i, mem_err_i;
  logic [31:0]       mem_rdata_i;
  logic              busy_o, timeout_o;

  mem_bus_arbiter #(
    .MEM_W         (MEM_W),
    .NUM_REQ       (NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i   (mem_err_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rv;
    logic [2:0]  er;
    logic [31:0] rd;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: either the queued response appears now, or no pulse at all.
  task automatic check_resp();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("resp_rvalid", 64'(rvalid_o), 64'(e.rv));
      chk("resp_err", 64'(err_o), 64'(e.er));
      chk("resp_rdata", 64'(rdata_o), 64'(e.rd));
      chk("resp_timeout", 64'(timeout_o), 64'(e.to));
    end else begin
      chk("no_pulse", 64'({rvalid_o, err_o, timeout_o}), 64'(0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_resp();
  endtask

  task automatic push(input logic [2:0] rv, input logic [2:0] er, input logic [31:0] rd,
                      input logic to);
    exp_t e;
    e.rv = rv;
    e.er = er;
    e.rd = rd;
    e.to = to;
    sb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({gnt_o, rvalid_o, err_o, mem_req_o, mem_we_o, mem_be_o, busy_o, timeout_o}),
        64'(0));
    chk({tag, "_addr"}, 64'({mem_addr_o, rdata_o}), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_wdata_o), 64'(0));
  endtask

  initial begin
    rst          = 1'b0;
    req_i        = '0;
    addr_i       = '0;
    we_i         = '0;
    be_i         = '0;
    wdata_i      = '0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;

    // Single read by requester 1, response on third BUSY cycle.
    addr_i[63:32] = 32'h0000_1004;
    be_i[7:4]     = 4'hF;
    req_i         = 3'b010;
    #1 chk("t1_gnt", 64'(gnt_o), 64'(3'b010));
    step();
    req_i = '0;
    chk("t1_req_c1", 64'({mem_req_o, busy_o, gnt_o}), 64'(5'b11_000));
    chk("t1_addr_c1", 64'(mem_addr_o), 64'(32'h1004));
    chk("t1_be", 64'({mem_we_o, mem_be_o}), 64'(5'b0_1111));
    step();
    chk("t1_req_c2", 64'(mem_req_o), 64'(1));
    step();
    chk("t1_req_c3", 64'(mem_req_o), 64'(1));
    chk("t1_addr_c3", 64'(mem_addr_o), 64'(32'h1004));
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    push(3'b010, 3'b000, 32'hDEAD_BEEF, 1'b0);
    step();
    mem_rvalid_i = 1'b0;
    chk("t1_idle", 64'({busy_o, mem_req_o}), 64'(0));

    // Round robin from a freshly reset pointer.
    rst = 1'b0;
    step();
    rst   = 1'b1;
    req_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_gnt", 64'(gnt_o), 64'(3'b001 << (k % 3)));
      step();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'(k + 100);
      push(3'(3'b001 << (k % 3)), 3'b000, 32'(k + 100), 1'b0);
      step();
      mem_rvalid_i = 1'b0;
    end
    req_i = '0;

    // Requester 2 write; error and rvalid together, error wins.
    addr_i[95:64]  = 32'h0000_2000;
    wdata_i[95:64] = 32'hCAFE_F00D;
    be_i[11:8]     = 4'h3;
    we_i           = 3'b100;
    req_i          = 3'b100;
    #1 chk("t3_gnt", 64'(gnt_o), 64'(3'b100));
    step();
    req_i = '0;
    we_i  = '0;
    chk("t3_we", 64'({mem_we_o, mem_be_o}), 64'(5'b1_0011));
    chk("t3_wdata", 64'(mem_wdata_o), 64'(32'hCAFE_F00D));
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    push(3'b000, 3'b100, 32'h0, 1'b0);
    step();
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;

    // Watchdog on requester 0, requester 1 waiting.
    req_i = 3'b011;
    #1 chk("t4_gnt0", 64'(gnt_o), 64'(3'b001));
    step();
    req_i = 3'b010;
    for (int i = 0; i < TO; i++) begin
      chk("t4_busy", 64'({mem_req_o, gnt_o}), 64'(4'b1_000));
      if (i == TO - 1) push(3'b000, 3'b001, 32'h0, 1'b1);
      step();
    end
    chk("t4_idle", 64'({mem_req_o, busy_o}), 64'(0));
    #1 chk("t4_gnt1", 64'(gnt_o), 64'(3'b010));
    step();
    req_i        = '0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55;
    push(3'b010, 3'b000, 32'h55, 1'b0);
    step();
    mem_rvalid_i = 1'b0;

    // Reset while BUSY drops the access silently.
    req_i = 3'b001;
    #1 chk("t5_gnt", 64'(gnt_o), 64'(3'b001));
    step();
    req_i = '0;
    step();
    chk("t5_busy", 64'(busy_o), 64'(1));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_all_zero("t5_after_rst");
    step();
    step();
    req_i = 3'b100;
    #1 chk("t5_gnt2", 64'(gnt_o), 64'(3'b100));
    step();
    req_i        = '0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h77;
    push(3'b100, 3'b000, 32'h77, 1'b0);
    step();
    mem_rvalid_i = 1'b0;

    // Spurious response in IDLE; pointer (now 0) must not move.
    step();
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    chk("t6_idle", 64'(busy_o), 64'(0));
    step();
    req_i = 3'b111;
    #1 chk("t6_gnt", 64'(gnt_o), 64'(3'b001));
    step();
    req_i        = '0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    push(3'b001, 3'b000, 32'h99, 1'b0);
    step();
    mem_rvalid_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory-mapped bus into the MMU between NUM_REQ requesters: Ibex instruction fetch, Ibex data, and Vicuna vector LSU.
- Round-robin grant with one outstanding transaction at a time.
- Latches the winner's request and holds it stable on the MMU side until the MMU responds.
- Routes the response back to the owning requester; a timeout watchdog errors out hung accesses.

Parameters:
MEM_W, 32, data bus width in bits (matches MMU and vproc_top)
NUM_REQ, 3, number of requesters (index 0 = highest priority after reset)
TIMEOUT_CYCLES, 1024, BUSY cycles without response before the access is aborted with error

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
req_i  input  NUM_REQ  per-requester request; held with fields stable until gnt_o
addr_i  input  NUM_REQ*32  per-requester address, packed, requester k at [32k+31:32k]
we_i  input  NUM_REQ  per-requester write enable
be_i  input  NUM_REQ*MEM_W/8  per-requester byte enables, packed
wdata_i  input  NUM_REQ*MEM_W  per-requester write data, packed
gnt_o  output  NUM_REQ  one-hot, one-cycle grant pulse
rvalid_o  output  NUM_REQ  one-hot, one-cycle response-valid pulse to the owner
err_o  output  NUM_REQ  one-hot, one-cycle error pulse to the owner
rdata_o  output  MEM_W  shared read data; valid only with rvalid_o
mem_req_o  output  1  request to MMU
mem_addr_o  output  32  latched address
mem_we_o  output  1  latched write enable
mem_be_o  output  MEM_W/8  latched byte enables
mem_wdata_o  output  MEM_W  latched write data
mem_rvalid_i  input  1  MMU response valid
mem_err_i  input  1  MMU error
mem_rdata_i  input  MEM_W  MMU read data
busy_o  output  1  high while a transaction is outstanding (state BUSY)
timeout_o  output  1  one-cycle pulse when the watchdog aborts an access

Behaviour:
- Reset (rst low at a clock edge):
  - state = IDLE, rr_ptr = 0, timeout counter = 0.
  - Every output is 0, including all mem_* outputs, rdata_o, and the one-hot vectors.
  - An outstanding transaction is dropped silently; no rvalid_o or err_o is issued for it.
- State IDLE:
  - If any req_i bit is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - In that cycle (combinationally): gnt_o[winner] = 1.
  - On the next edge: latch addr/we/be/wdata of the winner, owner = winner, counter = 0, state = BUSY.
  - With no request, remain in IDLE and keep mem_req_o = 0.
- State BUSY:
  - mem_req_o = 1 and mem_* = latched values, stable every cycle.
  - Requester inputs are ignored, and gnt_o = 0.
  - The counter increments each BUSY cycle.
- Response in BUSY cycle R (mem_rvalid_i or mem_err_i):
  - In cycle R+1, the registered rvalid_o[owner] or err_o[owner] pulses for one cycle.
  - On rvalid, rdata_o = mem_rdata_i captured at R; on err, rdata_o = 0.
  - State = IDLE at R+1, mem_req_o = 0 at R+1.
  - rr_ptr = (owner+1) mod NUM_REQ.
- Simultaneous mem_rvalid_i and mem_err_i: error wins; only err_o pulses and rdata_o = 0.
- Watchdog:
  - If the counter reaches TIMEOUT_CYCLES-1 in a BUSY cycle with no response, the next cycle gives err_o[owner] = 1, timeout_o = 1, and state IDLE.
  - rr_ptr advances exactly as for a normal response.
  - A response arriving in the same cycle as terminal count wins; timeout_o is not asserted.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter does not wrap, because terminal count exits BUSY.
- Grant timing: IDLE at R+1 may grant a new request in that same cycle, so back-to-back accesses leave one dead cycle (R+1) on mem_req_o.
- Minimum access cost is 1 grant cycle plus response latency plus 1.
- Responses arriving in IDLE (spurious) are ignored: no output pulse and no state change.
- NUM_REQ = 1 degenerates to pass-through with latch; rr_ptr stays 0.
- Requesters must not deassert req_i before gnt_o. Behaviour when they do is defined: the requester is not granted if req_i is low in the arbitration cycle.

Test Plan:
- Reset, then single request:
  - Stimulus: requester 1 reads addr 0x0000_1004 in cycle 0; MMU returns rvalid with rdata 0xDEADBEEF on the 3rd BUSY cycle.
  - Required: gnt_o = 3'b010 at cycle 0; mem_req_o high for cycles 1-3 with mem_addr_o = 0x1004; rvalid_o = 3'b010 and rdata_o = 0xDEADBEEF at cycle 4; busy_o low at cycle 4.
- Round-robin fairness:
  - Stimulus: all three req_i held high; MMU responds after 1 cycle each time.
  - Required: grant order 0, 1, 2, 0, 1, 2; no requester is granted twice before the others are served.
- Error precedence:
  - Stimulus: requester 2 write; mem_rvalid_i and mem_err_i both asserted in the same cycle.
  - Required: next cycle err_o = 3'b100, rvalid_o = 0, rdata_o = 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8; requester 0 granted; MMU never responds.
  - Required: mem_req_o high for exactly 8 cycles; then err_o = 3'b001 and timeout_o = 1 for one cycle; IDLE follows, and the next grant goes to requester 1 if it is requesting.
- Reset mid-transaction:
  - Stimulus: rst low while in BUSY.
  - Required: next cycle all outputs are 0, no rvalid_o/err_o pulse ever appears for the dropped access, and a post-reset request from requester 2 alone is granted with rr_ptr = 0.
- Spurious response:
  - Stimulus: mem_rvalid_i pulsed while in IDLE.
  - Required: no rvalid_o, state stays IDLE, rr_ptr unchanged.
